transmit_beamformer: RTL and testbench

Transmit-side counterpart of the receive beamformer. Once per ping period, drives NUM_TRANSMITTERS square-wave bursts at TARGET_FREQ. Each element's burst start is delayed so that the wavefront steers to the angle given by sin_theta/sign_bit. Sits between the angle/scan controller and the transducer driver pins, and emits period_start so the receive chain can align ranging.

---
 rtl/transmit_beamformer_pkg.sv | 32 +++
 rtl/transmit_beamformer_tx_channel.sv | 64 ++++++
 rtl/transmit_beamformer.sv | 138 +++++++++++++
 tb/tb_transmit_beamformer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/transmit_beamformer_pkg.sv
// Shared constants, state encoding and delay helper for the transmit beamformer.
`timescale 1ns/1ps
package beamform_pkg;

    localparam int SIN_W           = 16;
    localparam int DELAY_W         = 16;
    localparam int SIN_ONE         = 32768;
    localparam int DPE_CYC         = 9 * 100000000 / 343000;
    localparam int HALF_PERIOD_CYC = 100000000 / (2 * 40000);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CALC,
        ACTIVE,
        QUIET
    } tx_state_t;

    // floor(dpe * k * min(sin, 1.0) / 2^15)
    function automatic logic [DELAY_W-1:0] calc_delay(
        input logic [SIN_W-1:0] sin,
        input int               k,
        input int               dpe = DPE_CYC
    );
        logic [31:0] s;
        logic [31:0] p;
        s = (32'(sin) > 32'(SIN_ONE)) ? 32'(SIN_ONE) : 32'(sin);
        p = 32'(dpe) * 32'(k) * s;
        return p[DELAY_W+SIN_W-2:SIN_W-1];
    endfunction

endpackage

// File: rtl/transmit_beamformer_tx_channel.sv
// One element: delayed burst window with a half-period square-wave toggle.
`timescale 1ns/1ps
module tx_channel #(
    parameter int BASE  = 2,
    parameter int HALF  = 1250,
    parameter int BURST = 524288,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   count,
    input  logic [DW-1:0] d,
    input  logic          go,
    output logic          tx,
    output logic          win
);

    logic [31:0] len, len_n;
    logic [31:0] ph, ph_n;
    logic        tx_n, win_n;
    logic        start;

    // count is the value the period counter takes on the coming edge
    assign start = go && (count == 32'(BASE) + 32'(d));

    always_comb begin
        tx_n  = tx;
        win_n = win;
        len_n = len;
        ph_n  = ph;
        if (start) begin
            win_n = 1'b1;
            tx_n  = 1'b1;
            len_n = 32'd1;
            ph_n  = 32'd1;
        end else if (win && len == 32'(BURST)) begin
            win_n = 1'b0;
            tx_n  = 1'b0;
        end else if (win) begin
            len_n = len + 32'd1;
            if (ph == 32'(HALF)) begin
                ph_n = 32'd1;
                tx_n = ~tx;
            end else begin
                ph_n = ph + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx  <= 1'b0;
            win <= 1'b0;
            len <= '0;
            ph  <= '0;
        end else begin
            tx  <= tx_n;
            win <= win_n;
            len <= len_n;
            ph  <= ph_n;
        end
    end

endmodule

// File: rtl/transmit_beamformer.sv
// Ping sequencer: latches steering angle, derives element delays, fires bursts.
`timescale 1ns/1ps
module transmit_beamformer
    import beamform_pkg::*;
#(
    parameter int NUM_TRANSMITTERS = 4,
    parameter int CLK_FREQ         = 100000000,
    parameter int TARGET_FREQ      = 40000,
    parameter int PERIOD_DURATION  = 16777216,
    parameter int BURST_DURATION   = 524288,
    parameter int ELEMENT_SPACING  = 9,
    parameter int SPEED_OF_SOUND   = 343000,
    parameter int SIN_WIDTH        = 16,
    parameter int DELAY_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [SIN_WIDTH-1:0]        sin_theta,
    input  logic                        sign_bit,
    output logic [NUM_TRANSMITTERS-1:0] tx_out,
    output logic                        burst_active,
    output logic                        period_start
);

    localparam int N    = NUM_TRANSMITTERS;
    localparam int DPE  = int'(longint'(ELEMENT_SPACING) * longint'(CLK_FREQ)
                              / longint'(SPEED_OF_SOUND));
    localparam int HALF = CLK_FREQ / (2 * TARGET_FREQ);
    localparam int BASE = 2;

    if (longint'(BASE) + longint'(DPE) * longint'(N - 1)
        + longint'(BURST_DURATION) >= longint'(PERIOD_DURATION)) begin : g_bad_cfg
        $error("bursts do not fit inside the ping period");
    end

    tx_state_t            state, state_nxt;
    logic [31:0]          count, count_nxt;
    logic [31:0]          active_end;
    logic [SIN_WIDTH-1:0] s_q;
    logic                 sign_q;
    logic                 go;
    logic [DELAY_WIDTH-1:0] d_q    [N];
    logic [DELAY_WIDTH-1:0] d_calc [N];
    logic [DELAY_WIDTH-1:0] d_use  [N];
    logic [N-1:0]         tx_w, win_w;

    // during CALC the channels see the delay being registered this cycle
    always_comb begin
        for (int i = 0; i < N; i++) begin
            d_calc[i] = calc_delay(s_q, sign_q ? N - 1 - i : i, DPE);
            d_use[i]  = (state == CALC) ? d_calc[i] : d_q[i];
        end
    end

    assign active_end = 32'(BASE) + 32'(calc_delay(s_q, N - 1, DPE))
                      + 32'(BURST_DURATION) - 32'd1;
    assign go = (state == CALC) || (state == ACTIVE);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        unique case (state)
            IDLE: begin
                count_nxt = '0;
                if (enable) state_nxt = LATCH;
            end
            LATCH: begin
                count_nxt = 32'd1;
                state_nxt = CALC;
            end
            CALC: begin
                count_nxt = 32'd2;
                state_nxt = ACTIVE;
            end
            ACTIVE: begin
                count_nxt = count + 32'd1;
                if (count == active_end) state_nxt = QUIET;
            end
            QUIET: begin
                if (count == 32'(PERIOD_DURATION - 1)) begin
                    count_nxt = '0;
                    state_nxt = enable ? LATCH : IDLE;
                end else begin
                    count_nxt = count + 32'd1;
                end
            end
            default: begin
                count_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            s_q          <= '0;
            sign_q       <= 1'b0;
            period_start <= 1'b0;
            for (int i = 0; i < N; i++) d_q[i] <= '0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            period_start <= (state_nxt == LATCH);
            if (state == LATCH) begin
                s_q    <= (32'(sin_theta) > 32'(SIN_ONE))
                        ? SIN_WIDTH'(SIN_ONE) : sin_theta;
                sign_q <= sign_bit;
            end
            if (state == CALC) begin
                for (int i = 0; i < N; i++) d_q[i] <= d_calc[i];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        tx_channel #(
            .BASE (BASE),
            .HALF (HALF),
            .BURST(BURST_DURATION),
            .DW   (DELAY_WIDTH)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .count(count_nxt),
            .d    (d_use[i]),
            .go   (go),
            .tx   (tx_w[i]),
            .win  (win_w[i])
        );
    end

    assign tx_out       = tx_w;
    assign burst_active = |win_w;

endmodule

// File: tb/tb_transmit_beamformer.sv
// Cycle-by-cycle scoreboard bench for transmit_beamformer.
`timescale 1ns/1ps
module tb_transmit_beamformer;

    localparam int PERIOD = 20000;
    localparam int BURST  = 10000;
    localparam int HALF   = 1250;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] sin_theta;
    logic        sign_bit;
    logic [3:0]  tx_out;
    logic        burst_active;
    logic        period_start;

    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    logic [5:0] sb [$];
    logic [5:0] exp_v, act_v;

    typedef struct packed {
        logic [15:0]      sin;
        logic             sign;
        logic [3:0][15:0] d;
        logic [15:0]      n;
    } vec_t;

    vec_t tbl [4];

    transmit_beamformer #(
        .PERIOD_DURATION(PERIOD),
        .BURST_DURATION (BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sin_theta   (sin_theta),
        .sign_bit    (sign_bit),
        .tx_out      (tx_out),
        .burst_active(burst_active),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {period_start, burst_active, tx_out} at period count c
    function automatic logic [5:0] exp_at(input int c, input logic [3:0][15:0] d);
        logic [3:0] tx;
        logic       ba;
        tx = '0;
        ba = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int s;
            s = 2 + int'(d[i]);
            if (c >= s && c < s + BURST) begin
                ba = 1'b1;
                if (((c - s) / HALF) % 2 == 0) tx[i] = 1'b1;
            end
        end
        return {c == 0, ba, tx};
    endfunction

    task automatic cyc(input logic [5:0] e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        cyc_no++;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            act_v = {period_start, burst_active, tx_out};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cyc%0d ps/ba/tx act=%b exp=%b", cyc_no, act_v, exp_v);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][15:0] d0, d4;
        d0 = '0;
        d4 = {16'd7869, 16'd5246, 16'd2623, 16'd0};

        tbl[0] = '{sin: 16'd16384, sign: 1'b0,
                   d: {16'd3934, 16'd2623, 16'd1311, 16'd0}, n: 16'd14000};
        tbl[1] = '{sin: 16'd16384, sign: 1'b1,
                   d: {16'd0, 16'd1311, 16'd2623, 16'd3934}, n: 16'd6000};
        tbl[2] = '{sin: 16'hFFFF, sign: 1'b0,
                   d: {16'd7869, 16'd5246, 16'd2623, 16'd0}, n: 16'd8000};
        tbl[3] = '{sin: 16'd8192, sign: 1'b1,
                   d: {16'd0, 16'd655, 16'd1311, 16'd1967}, n: 16'd4000};

        rst_n     = 1'b0;
        enable    = 1'b0;
        sin_theta = '0;
        sign_bit  = 1'b0;
        repeat (3) cyc(6'b0);
        rst_n = 1'b1;
        repeat (3) cyc(6'b0);

        // each entry is cut short by a reset, mostly mid-burst
        for (int v = 0; v < 4; v++) begin
            rst_n     = 1'b1;
            enable    = 1'b1;
            sin_theta = tbl[v].sin;
            sign_bit  = tbl[v].sign;
            for (int c = 0; c < int'(tbl[v].n); c++) cyc(exp_at(c, tbl[v].d));
            rst_n  = 1'b0;
            enable = 1'b0;
            cyc(6'b0);
        end

        rst_n     = 1'b1;
        enable    = 1'b1;
        sin_theta = 16'd0;
        sign_bit  = 1'b0;
        for (int c = 0; c < PERIOD; c++) begin
            if (c == 500) sin_theta = 16'h8000;
            cyc(exp_at(c, d0));
        end
        for (int c = 0; c < PERIOD; c++) begin
            if (c == 6000) enable = 1'b0;
            cyc(exp_at(c, d4));
        end
        repeat (30) cyc(6'b0);

        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
